// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, state codes,
// ALUOP/PCSRC/ALUSRCB select values and the bundled datapath control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_ERR     = 4'd12,
    S_BNEEX   = 4'd13
  } state_t;

  // bne marks the inverted-zero branch condition used by BNEEX.
  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       bne;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational output decoder: maps the controller state (and mem_ready for
// the completion-cycle strobes) to the datapath control word.
module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = mem_ready;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_BEQEX, S_BNEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        ctrl.bne     = (state == S_BNEEX);
      end
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait timeout and sticky error state.
// Define MIPS_MC_BNE_EN to decode bne (op 000101) into BNEEX instead of ERR.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       err,
  output logic [3:0] state
);

  // Memory handshake: an access transfers in the cycle where mem_req and
  // mem_ready are both 1; mem_req stays high until then or until timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  ctrl_t      ctrl;
  logic       waiting, timeout;

  mips_mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign waiting = ctrl.mem_req && !mem_ready;
  assign timeout = waiting && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_RTYPEEX;
            OP_BEQ:       state_d = S_BEQEX;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JEX;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       state_d = S_BNEEX;
`endif
            default:      state_d = S_ERR;
          endcase
        end
        S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
        S_MEMWR:   if (mem_ready) state_d = S_FETCH;
        S_RTYPEEX: state_d = S_RTYPEWB;
        S_ADDIEX:  state_d = S_ADDIWB;
        S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_BNEEX, S_JEX: state_d = S_FETCH;
        S_ERR:     state_d = S_ERR;
        default:   state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wait_cnt <= 8'd0;
      else if (waiting)       wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign mem_req  = ctrl.mem_req;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign iord     = ctrl.iord;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  // BNEEX reuses the branch path with the zero sense inverted.
  assign pcen     = ctrl.pcwrite | (ctrl.branch & (zero ^ ctrl.bne));
  assign err      = (state_q == S_ERR);
  assign state    = state_q;

endmodule
